// File: rtl/data_bus_timer.sv
// Memory-mapped 64-bit timer on a data-bus slave port: prescaled counter, compare match,
// optional auto-reload and a level interrupt, with independent read and write handshakes.
module data_bus_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [63:0] ReadAddrIn,
  output logic [63:0] ReadDataOut,
  output logic        ReadReady,
  input  logic [63:0] WriteAddrIn,
  input  logic [63:0] WriteDataIn,
  input  logic [3:0]  WriteStrb,
  output logic        WriteReady,
  output logic        TimerIrq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] SEL_CTRL    = 2'd0;
  localparam logic [1:0] SEL_COUNT   = 2'd1;
  localparam logic [1:0] SEL_COMPARE = 2'd2;
  localparam logic [1:0] SEL_STATUS  = 2'd3;

  localparam logic [31:0] PRESCALE_LAST = 32'(PRESCALE - 1);

  // Each strobe bit covers one 16-bit lane of the write data.
  function automatic logic [63:0] strb_mask(input logic [3:0] strb);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 4; i++) begin
      m[16*i +: 16] = {16{strb[i]}};
    end
    return m;
  endfunction

  logic [1:0]  r_rd_state;
  logic [1:0]  r_wr_state;
  logic [63:0] r_rdata;
  logic        r_rready;
  logic        r_wready;
  logic [2:0]  r_ctrl;
  logic [63:0] r_count;
  logic [63:0] r_compare;
  logic        r_status;
  logic [31:0] r_presc;

  logic [63:0] w_rd_off;
  logic        w_rd_hit;
  logic [63:0] w_rd_data;
  logic [63:0] w_wr_off;
  logic        w_wr_hit;
  logic        w_wr_fire;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic [63:0] w_wmask;
  logic [63:0] w_wdata_m;
  logic        w_tick;
  logic [63:0] w_count_inc;
  logic        w_hit;

  assign w_rd_off = ReadAddrIn - BASE_ADDR;
  assign w_rd_hit = (ReadAddrIn >= BASE_ADDR) && (w_rd_off < 64'h20);
  assign w_wr_off = WriteAddrIn - BASE_ADDR;
  assign w_wr_hit = (WriteAddrIn >= BASE_ADDR) && (w_wr_off < 64'h20);

  assign w_wr_fire    = (r_wr_state == ST_IDLE) && (WriteAddrIn != 64'd0);
  assign w_wr_ctrl    = w_wr_fire && w_wr_hit && (w_wr_off[4:3] == SEL_CTRL);
  assign w_wr_count   = w_wr_fire && w_wr_hit && (w_wr_off[4:3] == SEL_COUNT);
  assign w_wr_compare = w_wr_fire && w_wr_hit && (w_wr_off[4:3] == SEL_COMPARE);
  assign w_wr_status  = w_wr_fire && w_wr_hit && (w_wr_off[4:3] == SEL_STATUS);

  assign w_wmask   = strb_mask(WriteStrb);
  assign w_wdata_m = WriteDataIn & w_wmask;

  assign w_tick      = r_ctrl[0] && (r_presc == PRESCALE_LAST);
  assign w_count_inc = r_count + 64'd1;
  assign w_hit       = w_tick && (w_count_inc == r_compare);

  // Read-data mux; unmapped addresses read as zero.
  always_comb begin
    w_rd_data = 64'd0;
    if (w_rd_hit) begin
      case (w_rd_off[4:3])
        SEL_CTRL:    w_rd_data = {61'd0, r_ctrl};
        SEL_COUNT:   w_rd_data = r_count;
        SEL_COMPARE: w_rd_data = r_compare;
        SEL_STATUS:  w_rd_data = {63'd0, r_status};
        default:     w_rd_data = 64'd0;
      endcase
    end else begin
      w_rd_data = 64'd0;
    end
  end

  // Read handshake: capture on request, one-cycle ready, wait for address to drop.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rd_state <= ST_IDLE;
      r_rdata    <= 64'd0;
      r_rready   <= 1'b0;
    end else begin
      case (r_rd_state)
        ST_IDLE: begin
          if (ReadAddrIn != 64'd0) begin
            r_rd_state <= ST_RESP;
            r_rdata    <= w_rd_data;
            r_rready   <= 1'b1;
          end
        end
        ST_RESP: begin
          r_rd_state <= ST_HOLD;
          r_rready   <= 1'b0;
        end
        ST_HOLD: begin
          if (ReadAddrIn == 64'd0) r_rd_state <= ST_IDLE;
        end
        default: begin
          r_rd_state <= ST_IDLE;
          r_rready   <= 1'b0;
        end
      endcase
    end
  end

  // Write handshake; the register update itself is keyed off w_wr_fire.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_state <= ST_IDLE;
      r_wready   <= 1'b0;
    end else begin
      case (r_wr_state)
        ST_IDLE: begin
          if (w_wr_fire) begin
            r_wr_state <= ST_RESP;
            r_wready   <= 1'b1;
          end
        end
        ST_RESP: begin
          r_wr_state <= ST_HOLD;
          r_wready   <= 1'b0;
        end
        ST_HOLD: begin
          if (WriteAddrIn == 64'd0) r_wr_state <= ST_IDLE;
        end
        default: begin
          r_wr_state <= ST_IDLE;
          r_wready   <= 1'b0;
        end
      endcase
    end
  end

  // CTRL and COMPARE are plain software registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ctrl    <= 3'd0;
      r_compare <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      if (w_wr_ctrl) r_ctrl <= (r_ctrl & ~w_wmask[2:0]) | w_wdata_m[2:0];
      if (w_wr_compare) r_compare <= (r_compare & ~w_wmask) | w_wdata_m;
    end
  end

  // Prescaler only advances while enabled and is never cleared by CTRL writes.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_presc <= 32'd0;
    end else if (r_ctrl[0]) begin
      r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
    end
  end

  // Software COUNT write beats increment/reload; match set beats W1C clear.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_count  <= 64'd0;
      r_status <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= (r_count & ~w_wmask) | w_wdata_m;
      end else if (w_tick) begin
        r_count <= (w_hit && r_ctrl[2]) ? 64'd0 : w_count_inc;
      end
      if (w_hit && !w_wr_count) begin
        r_status <= 1'b1;
      end else if (w_wr_status && w_wdata_m[0]) begin
        r_status <= 1'b0;
      end
    end
  end

  assign ReadDataOut = r_rdata;
  assign ReadReady   = r_rready;
  assign WriteReady  = r_wready;
  assign TimerIrq    = r_status & r_ctrl[1];

endmodule
